child_scheduler: RTL and testbench

//  Round-robin scheduler that shares one child/childBus-style compute unit among
//  N_REQ requesters. Grants one requester at a time and forwards its 1-bit i to the

---
 rtl/child_scheduler.sv | 157 +++++++++++++++
 tb/tb_child_scheduler.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/child_scheduler.sv
// Round-robin arbiter that time-shares one compute unit among N_REQ requesters.
// It launches one operation at a time, waits for done or a timeout, and returns the result.
module child_scheduler #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 15
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] i_i,
  output logic [N_REQ-1:0] ack_o,
  output logic             unit_start_o,
  output logic             unit_i_o,
  input  logic             unit_done_i,
  input  logic [4:0]       unit_return_i,
  output logic [4:0]       return_o,
  output logic             return_valid_o,
  output logic [ID_W-1:0]  return_id_o,
  output logic             return_err_o,
  input  logic             return_ready_i,
  output logic             busy_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_DELIVER = 2'd2;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [ID_W-1:0] ID_LAST = ID_W'(N_REQ - 1);

  logic [1:0]       state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             unit_start_q, unit_start_d;
  logic             unit_i_q, unit_i_d;
  logic [4:0]       return_q, return_d;
  logic             return_valid_q, return_valid_d;
  logic [ID_W-1:0]  return_id_q, return_id_d;
  logic             return_err_q, return_err_d;
  logic             busy_q, busy_d;

  logic [ID_W-1:0]  win;
  logic             found;

  // Scan requesters starting at rr_ptr, wrapping around; first set bit wins.
  always_comb begin
    int              idx_int;
    logic [ID_W-1:0] idx;
    win     = '0;
    found   = 1'b0;
    idx_int = 0;
    idx     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_int = int'(rr_ptr_q) + k;
      if (idx_int >= N_REQ) idx_int = idx_int - N_REQ;
      idx = ID_W'(idx_int);
      if (!found && req_i[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    cnt_d          = cnt_q;
    ack_d          = '0;
    unit_start_d   = 1'b0;
    unit_i_d       = unit_i_q;
    return_d       = return_q;
    return_valid_d = return_valid_q;
    return_id_d    = return_id_q;
    return_err_d   = return_err_q;
    busy_d         = busy_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          ack_d[win]   = 1'b1;
          unit_start_d = 1'b1;
          unit_i_d     = i_i[win];
          return_id_d  = win;
          cnt_d        = '0;
          state_d      = S_WAIT;
          busy_d       = 1'b1;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // A real completion takes priority over a timeout on the same edge.
        if (unit_done_i) begin
          return_d       = unit_return_i;
          return_err_d   = 1'b0;
          return_valid_d = 1'b1;
          state_d        = S_DELIVER;
        end else if (cnt_q == CNT_LAST) begin
          return_d       = 5'd0;
          return_err_d   = 1'b1;
          return_valid_d = 1'b1;
          state_d        = S_DELIVER;
        end
      end
      S_DELIVER: begin
        if (return_ready_i) begin
          return_valid_d = 1'b0;
          rr_ptr_d       = (return_id_q == ID_LAST) ? '0 : return_id_q + 1'b1;
          state_d        = S_IDLE;
          busy_d         = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q        <= S_IDLE;
      rr_ptr_q       <= '0;
      cnt_q          <= '0;
      ack_q          <= '0;
      unit_start_q   <= 1'b0;
      unit_i_q       <= 1'b0;
      return_q       <= '0;
      return_valid_q <= 1'b0;
      return_id_q    <= '0;
      return_err_q   <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      cnt_q          <= cnt_d;
      ack_q          <= ack_d;
      unit_start_q   <= unit_start_d;
      unit_i_q       <= unit_i_d;
      return_q       <= return_d;
      return_valid_q <= return_valid_d;
      return_id_q    <= return_id_d;
      return_err_q   <= return_err_d;
      busy_q         <= busy_d;
    end
  end

  assign ack_o          = ack_q;
  assign unit_start_o   = unit_start_q;
  assign unit_i_o       = unit_i_q;
  assign return_o       = return_q;
  assign return_valid_o = return_valid_q;
  assign return_id_o    = return_id_q;
  assign return_err_o   = return_err_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_child_scheduler.sv
// Directed testbench for child_scheduler; each task drives one scenario and checks
// outputs against hand-computed values.
module tb_child_scheduler;

  logic       clock;
  logic       reset_n;
  logic [3:0] req;
  logic [3:0] iv;
  logic [3:0] ack;
  logic       unit_start;
  logic       unit_i;
  logic       unit_done;
  logic [4:0] unit_return;
  logic [4:0] ret;
  logic       ret_valid;
  logic [1:0] ret_id;
  logic       ret_err;
  logic       ret_ready;
  logic       busy;

  int nChecks = 0;
  int nFails  = 0;

  child_scheduler #(.N_REQ(4), .ID_W(2), .TIMEOUT(15)) dut (
    .clock_i        (clock),
    .reset_ni       (reset_n),
    .req_i          (req),
    .i_i            (iv),
    .ack_o          (ack),
    .unit_start_o   (unit_start),
    .unit_i_o       (unit_i),
    .unit_done_i    (unit_done),
    .unit_return_i  (unit_return),
    .return_o       (ret),
    .return_valid_o (ret_valid),
    .return_id_o    (ret_id),
    .return_err_o   (ret_err),
    .return_ready_i (ret_ready),
    .busy_o         (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish (actual running, required finished)");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Waits up to 12 edges for a grant and returns the ack vector seen.
  task automatic wait_grant(output logic [3:0] a, output bit ok);
    a  = '0;
    ok = 1'b0;
    for (int n = 0; n < 12; n++) begin
      step();
      if (ack !== 4'b0000) begin
        a  = ack;
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req = 4'b1111; iv = 4'b0000;
    unit_done = 1'b0; unit_return = 5'd0; ret_ready = 1'b0;
    step(); step(); step();
    nChecks++; if (ack !== 4'b0000) begin nFails++; $display("[TB] FAIL reset_ack: got %b expected 0000", ack); end
    nChecks++; if (unit_start !== 1'b0) begin nFails++; $display("[TB] FAIL reset_start: got %b expected 0", unit_start); end
    nChecks++; if (ret_valid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_valid: got %b expected 0", ret_valid); end
    nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    reset_n = 1'b1;
    step();
    nChecks++; if (ack !== 4'b0001) begin nFails++; $display("[TB] FAIL reset_first_ack: got %b expected 0001", ack); end
    nChecks++; if (unit_start !== 1'b1) begin nFails++; $display("[TB] FAIL reset_first_start: got %b expected 1", unit_start); end
    req = 4'b0000;
    // unit_done during the start cycle must be accepted
    unit_done = 1'b1; unit_return = 5'd7;
    step();
    nChecks++; if (ret_valid !== 1'b1 || ret !== 5'd7 || ret_id !== 2'd0 || ret_err !== 1'b0) begin
      nFails++; $display("[TB] FAIL same_cycle_done: got v=%b r=%0d id=%0d e=%b expected v=1 r=7 id=0 e=0", ret_valid, ret, ret_id, ret_err);
    end
    unit_done = 1'b0; ret_ready = 1'b1;
    step();
    ret_ready = 1'b0;
    nChecks++; if (ret_valid !== 1'b0 || busy !== 1'b0) begin nFails++; $display("[TB] FAIL reset_release_idle: got v=%b busy=%b expected 0 0", ret_valid, busy); end
  endtask

  task automatic test_single();
    // rr_ptr is 1 here, so requester 2 wins
    req = 4'b0100; iv = 4'b0100;
    step();
    nChecks++; if (ack !== 4'b0100) begin nFails++; $display("[TB] FAIL single_ack: got %b expected 0100", ack); end
    nChecks++; if (unit_i !== 1'b1) begin nFails++; $display("[TB] FAIL single_unit_i: got %b expected 1", unit_i); end
    nChecks++; if (ret_id !== 2'd2) begin nFails++; $display("[TB] FAIL single_id_early: got %0d expected 2", ret_id); end
    req = 4'b0000; iv = 4'b0000;
    step();
    nChecks++; if (ack !== 4'b0000 || unit_start !== 1'b0) begin nFails++; $display("[TB] FAIL single_pulse_width: got ack=%b start=%b expected 0000 0", ack, unit_start); end
    nChecks++; if (unit_i !== 1'b1) begin nFails++; $display("[TB] FAIL single_unit_i_stable: got %b expected 1", unit_i); end
    step();
    unit_done = 1'b1; unit_return = 5'b11111;
    step();
    unit_done = 1'b0;
    nChecks++; if (ret_valid !== 1'b1 || ret !== 5'b11111 || ret_id !== 2'd2 || ret_err !== 1'b0) begin
      nFails++; $display("[TB] FAIL single_result: got v=%b r=%b id=%0d e=%b expected v=1 r=11111 id=2 e=0", ret_valid, ret, ret_id, ret_err);
    end
    ret_ready = 1'b1;
    step();
    ret_ready = 1'b0;
    nChecks++; if (ret_valid !== 1'b0 || busy !== 1'b0) begin nFails++; $display("[TB] FAIL single_done_idle: got v=%b busy=%b expected 0 0", ret_valid, busy); end
  endtask

  task automatic test_fairness();
    logic [3:0] a;
    bit         ok;
    int         order [5] = '{0, 1, 2, 3, 0};
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    req = 4'b1111; ret_ready = 1'b1; unit_done = 1'b1; unit_return = 5'd3;
    for (int g = 0; g < 5; g++) begin
      wait_grant(a, ok);
      nChecks++; if (!ok || a !== (4'b0001 << order[g])) begin
        nFails++; $display("[TB] FAIL fair_grant_%0d: got ack=%b expected %b", g, a, 4'b0001 << order[g]);
      end
    end
    req = 4'b1001;
    wait_grant(a, ok);
    nChecks++; if (!ok || a !== 4'b1000) begin nFails++; $display("[TB] FAIL fair_skip_to_3: got ack=%b expected 1000", a); end
    req = 4'b0000;
    step(); step();
    unit_done = 1'b0; ret_ready = 1'b0;
    nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL fair_final_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_timeout();
    int rise_at = -1;
    // rr_ptr is 0 here
    req = 4'b0010; iv = 4'b0000;
    step();
    nChecks++; if (ack !== 4'b0010 || unit_start !== 1'b1) begin nFails++; $display("[TB] FAIL timeout_grant: got ack=%b start=%b expected 0010 1", ack, unit_start); end
    req = 4'b0000;
    for (int n = 1; n <= 30; n++) begin
      step();
      if (ret_valid === 1'b1) begin
        rise_at = n;
        break;
      end
    end
    nChecks++; if (rise_at != 15) begin nFails++; $display("[TB] FAIL timeout_latency: got %0d cycles expected 15", rise_at); end
    nChecks++; if (ret !== 5'd0 || ret_err !== 1'b1 || ret_id !== 2'd1) begin
      nFails++; $display("[TB] FAIL timeout_result: got r=%0d e=%b id=%0d expected r=0 e=1 id=1", ret, ret_err, ret_id);
    end
    unit_done = 1'b1; unit_return = 5'h15;
    step();
    unit_done = 1'b0;
    nChecks++; if (ret_valid !== 1'b1 || ret !== 5'd0 || ret_err !== 1'b1) begin
      nFails++; $display("[TB] FAIL timeout_late_done: got v=%b r=%0d e=%b expected v=1 r=0 e=1", ret_valid, ret, ret_err);
    end
    ret_ready = 1'b1;
    step();
    ret_ready = 1'b0;
    nChecks++; if (ret_valid !== 1'b0) begin nFails++; $display("[TB] FAIL timeout_release: got v=%b expected 0", ret_valid); end
  endtask

  task automatic test_backpressure();
    // rr_ptr is 2 here, so requester 3 wins
    req = 4'b1000;
    step();
    nChecks++; if (ack !== 4'b1000) begin nFails++; $display("[TB] FAIL bp_grant: got ack=%b expected 1000", ack); end
    req = 4'b0001; unit_done = 1'b1; unit_return = 5'b01010;
    step();
    unit_done = 1'b0;
    for (int n = 0; n < 6; n++) begin
      step();
      nChecks++; if (ret_valid !== 1'b1 || ret !== 5'b01010 || ret_id !== 2'd3 || ack !== 4'b0000) begin
        nFails++; $display("[TB] FAIL bp_hold_%0d: got v=%b r=%b id=%0d ack=%b expected 1 01010 3 0000", n, ret_valid, ret, ret_id, ack);
      end
    end
    ret_ready = 1'b1;
    step();
    ret_ready = 1'b0;
    nChecks++; if (ret_valid !== 1'b0 || ack !== 4'b0000) begin nFails++; $display("[TB] FAIL bp_release: got v=%b ack=%b expected 0 0000", ret_valid, ack); end
    step();
    nChecks++; if (ack !== 4'b0001) begin nFails++; $display("[TB] FAIL bp_next_grant: got ack=%b expected 0001", ack); end
    req = 4'b0000; unit_done = 1'b1; unit_return = 5'd1;
    step();
    unit_done = 1'b0; ret_ready = 1'b1;
    step();
    ret_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    // rr_ptr is 1 here, so requester 2 wins
    req = 4'b0100; iv = 4'b0100;
    step();
    nChecks++; if (ack !== 4'b0100) begin nFails++; $display("[TB] FAIL ar_grant: got ack=%b expected 0100", ack); end
    req = 4'b0000;
    step(); step();
    #2;
    reset_n = 1'b0;
    #1;
    nChecks++; if (busy !== 1'b0 || unit_start !== 1'b0 || ret_valid !== 1'b0) begin
      nFails++; $display("[TB] FAIL ar_immediate: got busy=%b start=%b v=%b expected 0 0 0", busy, unit_start, ret_valid);
    end
    step();
    reset_n = 1'b1;
    unit_done = 1'b1; unit_return = 5'h1F;
    step();
    unit_done = 1'b0;
    nChecks++; if (ret_valid !== 1'b0 || busy !== 1'b0) begin nFails++; $display("[TB] FAIL ar_no_return: got v=%b busy=%b expected 0 0", ret_valid, busy); end
    req = 4'b1111;
    step();
    nChecks++; if (ack !== 4'b0001) begin nFails++; $display("[TB] FAIL ar_rr_ptr_zero: got ack=%b expected 0001", ack); end
    req = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_backpressure();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
